// File: rtl/pc_pkg.sv
// Shared types and defaults for the program-counter sequencer: redirect
// priority encoding, sequencer states and default vectors/increment.
package pc_pkg;

    typedef enum logic [1:0] {
        PRI_NONE   = 2'd0,
        PRI_JUMP   = 2'd1,
        PRI_BRANCH = 2'd2,
        PRI_EXC    = 2'd3
    } pri_e;

    typedef enum logic {
        ST_RUN  = 1'b0,
        ST_HOLD = 1'b1
    } seq_state_e;

    localparam logic [31:0] DEF_RESET_VECTOR = 32'h0000_0000;
    localparam logic [31:0] DEF_EXC_VECTOR   = 32'h0000_8000;
    localparam int unsigned DEF_PC_INC       = 4;

    // A newer request displaces a held one when it is at least as urgent.
    function automatic logic pri_wins(pri_e req, pri_e held);
        return req >= held;
    endfunction

endpackage

// File: rtl/pc_redirect_arb.sv
// Combinational redirect arbiter: picks the most urgent of exception, branch
// and jump, and returns its target with the low ALIGN_BITS forced to zero.
module pc_redirect_arb
    import pc_pkg::*;
#(
    parameter int unsigned            ADDR_WIDTH = 32,
    parameter int unsigned            ALIGN_BITS = 2,
    parameter logic [ADDR_WIDTH-1:0]  EXC_VECTOR = ADDR_WIDTH'(DEF_EXC_VECTOR)
) (
    input  logic                  exc_i,
    input  logic                  branch_i,
    input  logic [ADDR_WIDTH-1:0] branch_tgt_i,
    input  logic                  jump_i,
    input  logic [ADDR_WIDTH-1:0] jump_tgt_i,
    output logic                  valid_o,
    output logic [1:0]            pri_o,
    output logic [ADDR_WIDTH-1:0] tgt_o
);

    localparam logic [ADDR_WIDTH-1:0] ALIGN_MASK = {ADDR_WIDTH{1'b1}} << ALIGN_BITS;

    logic [ADDR_WIDTH-1:0] rawTgt;

    always_comb begin
        valid_o = 1'b0;
        pri_o   = PRI_NONE;
        rawTgt  = '0;
        if (exc_i) begin
            valid_o = 1'b1;
            pri_o   = PRI_EXC;
            rawTgt  = EXC_VECTOR;
        end else if (branch_i) begin
            valid_o = 1'b1;
            pri_o   = PRI_BRANCH;
            rawTgt  = branch_tgt_i;
        end else if (jump_i) begin
            valid_o = 1'b1;
            pri_o   = PRI_JUMP;
            rawTgt  = jump_tgt_i;
        end
        tgt_o = rawTgt & ALIGN_MASK;
    end

endmodule

// File: rtl/pc_sequencer.sv
// Fetch PC register with sequential increment, stall hold and a one-entry
// pending redirect. Define PC_EXC_REDIRECT_EN to add Exception/EPC handling.
module pc_sequencer
    import pc_pkg::*;
#(
    parameter int unsigned            ADDR_WIDTH   = 32,
    parameter logic [ADDR_WIDTH-1:0]  RESET_VECTOR = ADDR_WIDTH'(DEF_RESET_VECTOR),
    parameter int unsigned            PC_INC       = DEF_PC_INC,
    parameter int unsigned            ALIGN_BITS   = 2,
    parameter logic [ADDR_WIDTH-1:0]  EXC_VECTOR   = ADDR_WIDTH'(DEF_EXC_VECTOR)
) (
    input  logic                  Clk,
    input  logic                  Reset,
    input  logic                  PCoff,
    input  logic                  BranchTaken,
    input  logic [ADDR_WIDTH-1:0] BranchTarget,
    input  logic                  Jump,
    input  logic [ADDR_WIDTH-1:0] JumpTarget,
`ifdef PC_EXC_REDIRECT_EN
    input  logic                  Exception,
`endif
    output logic [ADDR_WIDTH-1:0] PCResult,
    output logic [ADDR_WIDTH-1:0] PCPlus4,
    output logic [ADDR_WIDTH-1:0] PrevPC,
    output logic                  RedirectPending
`ifdef PC_EXC_REDIRECT_EN
   ,output logic [ADDR_WIDTH-1:0] EPC
`endif
);

    localparam logic [ADDR_WIDTH-1:0] PC_INC_W = ADDR_WIDTH'(PC_INC);

    logic [ADDR_WIDTH-1:0] pc_q, pc_d;
    logic [ADDR_WIDTH-1:0] prev_q, prev_d;
    logic [ADDR_WIDTH-1:0] pend_tgt_q, pend_tgt_d;
    pri_e                  pend_pri_q, pend_pri_d;
    seq_state_e            state_q, state_d;

    logic                  excReq;
    logic                  reqValid;
    logic [1:0]            reqPriRaw;
    pri_e                  reqPri;
    logic [ADDR_WIDTH-1:0] reqTgt;
    logic                  takeNew;

`ifdef PC_EXC_REDIRECT_EN
    logic [ADDR_WIDTH-1:0] epc_q, epc_d;
    assign excReq = Exception;
    assign EPC    = epc_q;
`else
    assign excReq = 1'b0;
`endif

    pc_redirect_arb #(
        .ADDR_WIDTH (ADDR_WIDTH),
        .ALIGN_BITS (ALIGN_BITS),
        .EXC_VECTOR (EXC_VECTOR)
    ) u_arb (
        .exc_i        (excReq),
        .branch_i     (BranchTaken),
        .branch_tgt_i (BranchTarget),
        .jump_i       (Jump),
        .jump_tgt_i   (JumpTarget),
        .valid_o      (reqValid),
        .pri_o        (reqPriRaw),
        .tgt_o        (reqTgt)
    );

    assign reqPri  = pri_e'(reqPriRaw);
    assign takeNew = reqValid && pri_wins(reqPri, pend_pri_q);

    always_comb begin
        pc_d       = pc_q;
        prev_d     = prev_q;
        pend_tgt_d = pend_tgt_q;
        pend_pri_d = pend_pri_q;
        state_d    = state_q;
`ifdef PC_EXC_REDIRECT_EN
        epc_d      = epc_q;
`endif
        case (state_q)
            ST_RUN: begin
                if (!PCoff) begin
                    pc_d = reqValid ? reqTgt : pc_q + PC_INC_W;
                end else if (reqValid) begin
                    state_d    = ST_HOLD;
                    pend_tgt_d = reqTgt;
                    pend_pri_d = reqPri;
                end
            end
            ST_HOLD: begin
                if (PCoff) begin
                    if (takeNew) begin
                        pend_tgt_d = reqTgt;
                        pend_pri_d = reqPri;
                    end
                end else begin
                    // Leaving HOLD loads the redirect only; no increment this cycle.
                    pc_d       = takeNew ? reqTgt : pend_tgt_q;
                    state_d    = ST_RUN;
                    pend_tgt_d = '0;
                    pend_pri_d = PRI_NONE;
                end
            end
            default: state_d = ST_RUN;
        endcase
`ifdef PC_EXC_REDIRECT_EN
        // An exception bypasses the stall and flushes any held redirect.
        if (reqValid && reqPri == PRI_EXC) begin
            pc_d       = reqTgt;
            epc_d      = pc_q;
            state_d    = ST_RUN;
            pend_tgt_d = '0;
            pend_pri_d = PRI_NONE;
        end
`endif
        if (pc_d != pc_q) begin
            prev_d = pc_q;
        end
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            pc_q       <= RESET_VECTOR;
            prev_q     <= RESET_VECTOR;
            pend_tgt_q <= '0;
            pend_pri_q <= PRI_NONE;
            state_q    <= ST_RUN;
`ifdef PC_EXC_REDIRECT_EN
            epc_q      <= '0;
`endif
        end else begin
            pc_q       <= pc_d;
            prev_q     <= prev_d;
            pend_tgt_q <= pend_tgt_d;
            pend_pri_q <= pend_pri_d;
            state_q    <= state_d;
`ifdef PC_EXC_REDIRECT_EN
            epc_q      <= epc_d;
`endif
        end
    end

    assign PCResult        = pc_q;
    assign PrevPC          = prev_q;
    assign PCPlus4         = pc_q + PC_INC_W;
    assign RedirectPending = (state_q == ST_HOLD);

endmodule
